// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV32I controller.
//   state_t   : 4-bit FSM state encoding (also exported on state_o for debug)
//   OP_*      : RV32I major opcodes decoded by the controller
//   PCS_/M2R_/SRCA_/SRCB_/ALU_ : datapath select encodings
//   is_mem_state() : states that issue a memory request and may wait on mem_ready
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MA    = 4'd2,
        S_MEM_R = 4'd3,
        S_MRCS  = 4'd4,
        S_MEM_W = 4'd5,
        S_EX    = 4'd6,
        S_EXI   = 4'd7,
        S_LUI   = 4'd8,
        S_RT    = 4'd9,
        S_BC    = 4'd10,
        S_JAL   = 4'd11,
        S_JALR  = 4'd12,
        S_ILL   = 4'd13,
        S_FAULT = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;

    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    localparam logic [1:0] SRCA_OLDPC  = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_ZERO   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_BRANCH  = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;
    localparam logic [1:0] ALU_IFUNCT  = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_IF) || (s == S_MEM_R) || (s == S_MEM_W);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive cycles a memory access is stalled.
//   clk, reset : clock, async active-high reset
//   waiting    : controller is in a state that issues a memory request
//   mem_ready  : memory completes the access this cycle
//   expired    : this stalled cycle is the MEM_TIMEOUT-th in a row
// MEM_TIMEOUT = 0 disables the timeout (expired never asserts).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);
    // Counter holds the number of stalls already seen, so the limit is one less.
    localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : {CW{1'b0}};

    logic [CW-1:0] count_r;
    logic          hit_s;

    // mem_ready has priority: a completing access never expires.
    assign hit_s   = TIMEOUT_EN && waiting && !mem_ready && (count_r == LIMIT);
    assign expired = hit_s;

    // Stall counter; any exit from a waiting state happens on mem_ready or expiry, which clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (!TIMEOUT_EN || !waiting || mem_ready || hit_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control FSM.
//   clk, reset   : clock, async active-high reset (all outputs forced to 0 while high)
//   opcode       : IR[6:0]
//   mem_ready    : memory completes the current access this cycle
//   PCWriteCond, PCWrite, IorD, PCSource, MemRead, MemWrite, MemtoReg,
//   IRWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp : datapath controls
//   illegal      : one-cycle pulse on an unsupported opcode
//   fault        : sticky memory-timeout fault, cleared only by reset
//   state_o      : current state encoding for debug
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int HAS_IMM_ALU = 1,
    parameter int HAS_JUMP    = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic [1:0] PCSource,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam logic IMM_EN  = (HAS_IMM_ALU != 0);
    localparam logic JUMP_EN = (HAS_JUMP != 0);

    state_t state_r;
    state_t next_s;
    logic   expired_s;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (is_mem_state(state_r)),
        .mem_ready(mem_ready),
        .expired  (expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IF: begin
                if (mem_ready)      next_s = S_ID;
                else if (expired_s) next_s = S_FAULT;
                else                next_s = S_IF;
            end
            S_ID: begin
                case (opcode)
                    OP_R:               next_s = S_EX;
                    OP_IMM:             next_s = IMM_EN  ? S_EXI  : S_ILL;
                    OP_LOAD, OP_STORE:  next_s = S_MA;
                    OP_BRANCH:          next_s = S_BC;
                    OP_JAL:             next_s = JUMP_EN ? S_JAL  : S_ILL;
                    OP_JALR:            next_s = JUMP_EN ? S_JALR : S_ILL;
                    OP_LUI:             next_s = JUMP_EN ? S_LUI  : S_ILL;
                    OP_AUIPC:           next_s = JUMP_EN ? S_RT   : S_ILL;
                    default:            next_s = S_ILL;
                endcase
            end
            S_MA: begin
                if (opcode == OP_LOAD)       next_s = S_MEM_R;
                else if (opcode == OP_STORE) next_s = S_MEM_W;
                else                         next_s = S_IF;
            end
            S_MEM_R: begin
                if (mem_ready)      next_s = S_MRCS;
                else if (expired_s) next_s = S_FAULT;
                else                next_s = S_MEM_R;
            end
            S_MEM_W: begin
                if (mem_ready)      next_s = S_IF;
                else if (expired_s) next_s = S_FAULT;
                else                next_s = S_MEM_W;
            end
            S_EX, S_EXI, S_LUI:                    next_s = S_RT;
            S_MRCS, S_RT, S_BC, S_JAL, S_JALR, S_ILL: next_s = S_IF;
            S_FAULT:                               next_s = S_FAULT;
            default:                               next_s = S_IF;
        endcase
    end

    // Moore output decode; fetch completion strobes are qualified by mem_ready.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        PCSource    = PCS_ALU;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = M2R_ALUOUT;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_ADD;
        illegal     = 1'b0;
        fault       = 1'b0;
        state_o     = 4'd0;
        if (reset) begin
            // Hold everything low so no strobe can escape during or around reset.
            state_o = 4'd0;
        end else begin
            state_o = state_r;
            case (state_r)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_ID: ALUSrcB = SRCB_IMM;
                S_MA: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_R: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MRCS: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_MDR;
                end
                S_MEM_W: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EX: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALU_FUNCT;
                end
                S_EXI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_IFUNCT;
                end
                S_LUI: begin
                    ALUSrcA = SRCA_ZERO;
                    ALUSrcB = SRCB_IMM;
                end
                S_RT: RegWrite = 1'b1;
                S_BC: begin
                    ALUSrcA     = SRCA_RS1;
                    ALUOp       = ALU_BRANCH;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                end
                S_JAL: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_PC;
                    PCWrite  = 1'b1;
                    PCSource = PCS_ALUOUT;
                end
                S_JALR: begin
                    // A was latched in ID, so rd == rs1 cannot corrupt the target.
                    ALUSrcA  = SRCA_RS1;
                    ALUSrcB  = SRCB_IMM;
                    RegWrite = 1'b1;
                    MemtoReg = M2R_PC;
                    PCWrite  = 1'b1;
                end
                S_ILL:   illegal = 1'b1;
                S_FAULT: fault   = 1'b1;
                default: state_o = state_r;
            endcase
        end
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle RV32I control FSM, the next generation of our multicycle controller. Drives datapath mux selects and write strobes from a 7-bit opcode. Adds I-type ALU, JAL, JALR, LUI and AUIPC. Adds a mem_ready wait handshake on every memory access, a memory-wait timeout leading to a sticky fault, and an illegal-opcode pulse.

Parameters:
HAS_IMM_ALU, 1, enables opcode 0010011 (I-type ALU); 0 makes it illegal
HAS_JUMP, 1, enables JAL/JALR/LUI/AUIPC; 0 makes them illegal
MEM_TIMEOUT, 16, max consecutive wait cycles per access; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
opcode  in  7  IR[6:0]
mem_ready  in  1  memory completes the access this cycle
PCWriteCond  out  1  conditional PC write (branch)
PCWrite  out  1  unconditional PC write
IorD  out  1  0=PC address, 1=ALUOut address
PCSource  out  2  00=ALU result, 01=ALUOut, 10/11 reserved
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC (link)
IRWrite  out  1  latch IR and OldPC
RegWrite  out  1  register file write
ALUSrcA  out  2  00=OldPC, 01=A (rs1), 10=zero
ALUSrcB  out  2  00=B, 01=const 4, 10=imm
ALUOp  out  2  00=add, 01=branch compare, 10=funct decode, 11=I-type funct decode
illegal  out  1  one-cycle pulse on an unsupported opcode
fault  out  1  sticky memory-timeout fault
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset is asynchronous. It sets state=IF, clears the wait counter, and clears fault.
- While reset is high, every output is 0, including selects. state_o=IF.
- Outputs are a Moore decode of the state, except that the strobes in wait states are qualified by mem_ready as listed below. Any output not listed for a state is 0.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00, then go to ID. Otherwise stay in IF.
- ID:
  - ALUSrcA=00, ALUSrcB=10, ALUOp=00, so ALUOut <= OldPC+imm.
  - Decode: 0110011->EX; 0010011->EXI; 0000011/0100011->MA; 1100011->BC; 1101111->JAL; 1100111->JALR; 0110111->LUI; 0010111->RT (AUIPC). Anything else, or a disabled extension, goes to ILL.
- MA: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Load->MEM_R, store->MEM_W, otherwise IF.
- MEM_R: IorD=1, MemRead=1. Stay until mem_ready=1, then go to MRCS.
- MEM_W: IorD=1, MemWrite=1. Stay until mem_ready=1, then go to IF.
- MRCS: RegWrite=1, MemtoReg=01. Go to IF.
- EX: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Go to RT.
- EXI: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Go to RT.
- LUI: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Go to RT.
- RT: RegWrite=1, MemtoReg=00. Go to IF.
- BC: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to IF.
- JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01. Go to IF.
- JALR:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=00. Go to IF.
  - The datapath clears target bit 0.
  - rs1==rd is safe because A was latched in ID.
- ILL: illegal=1 for exactly one cycle, then go to IF.
- FAULT: all strobes 0. Exit only by reset.
- Instruction latencies with mem_ready tied to 1:
  - 4 cycles: R, I, LUI, store.
  - 3 cycles: AUIPC, BC, JAL, JALR, ILL.
  - 5 cycles: load.
  - Each wait cycle adds 1.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in IF, MEM_R or MEM_W. Cleared on mem_ready=1 or on state change. Width is clog2(MEM_TIMEOUT+1).
  - If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT, the next state is FAULT. No completion strobe is issued in that cycle.
- If mem_ready is high in the same cycle the timeout is reached, mem_ready wins.
- mem_ready is ignored in non-memory states.
- Reset during a wait aborts the access. No partial write strobe may follow reset release.

Decomposition:
- ctrl_pkg: state_t enum (4-bit: IF, ID, MA, MEM_R, MRCS, MEM_W, EX, EXI, LUI, RT, BC, JAL, JALR, ILL, FAULT), OP_* opcode localparams, and encodings for PCSource, MemtoReg, ALUSrcA, ALUSrcB and ALUOp.
- Sub-module mem_wait_timer: takes MEM_TIMEOUT; inputs clk, reset, waiting, mem_ready; output expired.

Test Plan:
1. R-type 0110011, mem_ready=1 -> states IF,ID,EX,RT; IRWrite/PCWrite high in cycle 0 only; RegWrite high in cycle 3 only; back in IF at cycle 4.
2. Load 0000011, mem_ready low for 3 cycles in MEM_R -> MEM_R held 4 cycles with MemRead=1, IorD=1; RegWrite=1, MemtoReg=01 in the cycle after mem_ready rises.
3. JAL 1101111 -> cycle 2: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10. With HAS_JUMP=0 -> illegal pulse 1 cycle, no RegWrite, return to IF.
4. MEM_TIMEOUT=4, mem_ready held 0 in IF -> FAULT entered after 4 wait cycles; fault=1 and all strobes 0 for 20+ cycles; clears only on reset.
5. Store, reset asserted mid-MEM_W -> outputs 0 immediately (asynchronous); after release, state IF with no MemWrite.
6. Opcode 1111111 -> IF,ID,ILL; illegal=1 exactly one cycle; no RegWrite, PCWrite beyond fetch, or MemWrite.
